// File: rtl/display_pkg.sv
// Shared types and limits for the hex display scheduler.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_DV = 2'd2,
    HOLD    = 2'd3
  } sched_state_e;

  // Largest value the six-digit display can show.
  localparam logic [19:0] MAX_DISPLAY = 20'd999999;

endpackage

// File: rtl/hex_display_scheduler_cycle_timer.sv
// cycle_timer: loadable down-counter; o_done is high while the count is zero.
// The scheduler reloads it on entry to each timed state.
module cycle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load on request, otherwise count down and rest at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: time-shares one BCD hex driver between N_CH channels.
// Latches the newest value per channel, loads the selected one (clamped to six
// digits) into the driver, waits for its ready pulse, then holds for a refresh.
module hex_display_scheduler
  import display_pkg::*;
#(
  parameter int N_CH           = 3,
  parameter int DATA_W         = 20,
  parameter int REFRESH_CYCLES = 500000,
  parameter int DWELL_REFRESH  = 8,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SEL_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic                   auto_cycle,
  input  logic [SEL_W-1:0]       manual_sel,
  output logic [DATA_W-1:0]      number_out,
  output logic                   update,
  input  logic                   driver_ready,
  output logic [SEL_W-1:0]       active_ch,
  output logic                   overflow,
  output logic                   conv_timeout
);

  localparam int MAX_CNT = (REFRESH_CYCLES > TIMEOUT_CYCLES) ? REFRESH_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int DWELL_W = (DWELL_REFRESH > 1) ? $clog2(DWELL_REFRESH + 1) : 1;
  localparam int CMP_W   = (DATA_W > 20) ? DATA_W : 20;

  // True when the value cannot be shown in six decimal digits.
  function automatic logic over_limit(input logic [DATA_W-1:0] v);
    return CMP_W'(v) > CMP_W'(MAX_DISPLAY);
  endfunction

  // Saturate to the display maximum.
  function automatic logic [DATA_W-1:0] clamp_display(input logic [DATA_W-1:0] v);
    return over_limit(v) ? DATA_W'(CMP_W'(MAX_DISPLAY)) : v;
  endfunction

  sched_state_e       r_state;
  sched_state_e       w_next_state;
  logic               r_rel;
  logic [DATA_W-1:0]  r_hold [N_CH];
  logic [DATA_W-1:0]  r_number;
  logic               r_update;
  logic               r_overflow;
  logic               r_timeout;
  logic [SEL_W-1:0]   r_active_ch;
  logic [DWELL_W-1:0] r_dwell;
  logic               w_tmr_load;
  logic [CNT_W-1:0]   w_tmr_val;
  logic               w_tmr_done;
  logic               w_timeout_evt;
  logic               w_hold_exit;
  logic [DATA_W-1:0]  w_sel_val;

  assign w_sel_val = r_hold[r_active_ch];

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // Release stage: the FSM leaves IDLE one cycle after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rel <= 1'b0;
    else          r_rel <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next state, timer reload and event strobes.
  always_comb begin
    w_next_state  = r_state;
    w_tmr_load    = 1'b0;
    w_tmr_val     = CNT_W'(REFRESH_CYCLES - 1);
    w_timeout_evt = 1'b0;
    w_hold_exit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rel) w_next_state = LOAD;
      end
      LOAD: begin
        w_next_state = WAIT_DV;
        w_tmr_load   = 1'b1;
        w_tmr_val    = CNT_W'(TIMEOUT_CYCLES - 1);
      end
      WAIT_DV: begin
        // A ready on the final timeout cycle still counts as success.
        if (driver_ready) begin
          w_next_state = HOLD;
          w_tmr_load   = 1'b1;
        end else if (w_tmr_done) begin
          w_next_state  = HOLD;
          w_tmr_load    = 1'b1;
          w_timeout_evt = 1'b1;
        end
      end
      HOLD: begin
        if (w_tmr_done) begin
          w_next_state = LOAD;
          w_hold_exit  = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Per-channel capture, independent of the scheduler state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_CH; k++) r_hold[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (ch_valid[k]) r_hold[k] <= ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Driver load: value and overflow are taken from the pre-edge hold register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_number   <= '0;
      r_update   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_update <= (r_state == LOAD);
      if (r_state == LOAD) begin
        r_number   <= clamp_display(w_sel_val);
        r_overflow <= over_limit(w_sel_val);
      end
    end
  end

  // Sticky conversion-timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_timeout <= 1'b0;
    else if (w_timeout_evt) r_timeout <= 1'b1;
  end

  // Channel selection, applied only when a refresh period ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active_ch <= '0;
      r_dwell     <= '0;
    end else if (w_hold_exit) begin
      if (auto_cycle) begin
        if (r_dwell == DWELL_W'(DWELL_REFRESH - 1)) begin
          r_dwell     <= '0;
          r_active_ch <= (r_active_ch == SEL_W'(N_CH - 1)) ? '0 : r_active_ch + 1'b1;
        end else begin
          r_dwell <= r_dwell + 1'b1;
        end
      end else begin
        r_dwell     <= '0;
        r_active_ch <= (int'(manual_sel) >= N_CH) ? '0 : manual_sel;
      end
    end
  end

  assign number_out   = r_number;
  assign update       = r_update;
  assign overflow     = r_overflow;
  assign conv_timeout = r_timeout;
  assign active_ch    = r_active_ch;

endmodule
